// File: rtl/jtag_dtm_regs.sv
// RISC-V debug transport module register stage behind a JTAG TAP.
// Holds the IR and the IDCODE/BYPASS/DTMCS/DMI data registers, and bridges DMI scans to the DM.
module jtag_dtm_regs #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1DEAD3FF,
  parameter int unsigned ABITS        = 7,
  parameter logic [2:0]  IDLE_HINT    = 3'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tdi,
  output logic             tdo,
  input  logic             tap_reset,
  input  logic             capture_ir,
  input  logic             shift_ir,
  input  logic             update_ir,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_op,
  output logic [4:0]       ir_value
);

  localparam int unsigned DMI_W       = ABITS + 34;
  localparam logic [5:0]  ABITS_FIELD = 6'(ABITS);
  localparam logic [4:0]  IR_IDCODE   = 5'h01;
  localparam logic [4:0]  IR_DTMCS    = 5'h10;
  localparam logic [4:0]  IR_DMI      = 5'h11;

  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} dr_sel_e;
  typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_RESP} dmi_state_e;

  logic [4:0]       ir, ir_shift;
  logic [31:0]      idcode_shift, dtmcs_shift;
  logic             bypass_shift;
  logic [DMI_W-1:0] dmi_shift;
  logic [1:0]       dmistat;
  logic [ABITS-1:0] last_addr;
  logic [31:0]      last_data;
  dmi_state_e       state_q, state_d;
  dr_sel_e          dr_sel;

  always_comb begin
    case (ir)
      IR_IDCODE: dr_sel = SEL_IDCODE;
      IR_DTMCS:  dr_sel = SEL_DTMCS;
      IR_DMI:    dr_sel = SEL_DMI;
      default:   dr_sel = SEL_BYPASS;
    endcase
  end

  logic             dmi_busy, dmi_update, dmi_launch, dmi_hardreset, dmi_reset, busy_hit, resp_fire;
  logic [1:0]       upd_op;
  logic [31:0]      dtmcs_capture;
  logic [DMI_W-1:0] dmi_capture;

  assign dmi_busy      = (state_q != DMI_IDLE);
  assign upd_op        = dmi_shift[1:0];
  assign dmi_update    = update_dr && (dr_sel == SEL_DMI);
  assign dmi_launch    = dmi_update && !dmi_busy && (dmistat == 2'd0)
                         && (upd_op == 2'd1 || upd_op == 2'd2);
  assign dmi_hardreset = update_dr && (dr_sel == SEL_DTMCS) && dtmcs_shift[17];
  assign dmi_reset     = update_dr && (dr_sel == SEL_DTMCS) && dtmcs_shift[16];
  // Any DMI access (capture or update) that lands on an in-flight transaction is a busy error.
  assign busy_hit      = dmi_busy && (dr_sel == SEL_DMI) && (capture_dr || update_dr);
  assign resp_fire     = (state_q == DMI_RESP) && dmi_resp_valid && !dmi_hardreset;

  assign dtmcs_capture = {14'b0, 2'b0, 1'b0, IDLE_HINT, dmistat, ABITS_FIELD, 4'h1};
  assign dmi_capture   = {last_addr, last_data, dmi_busy ? 2'd3 : dmistat};

  assign ir_value       = ir;
  assign dmi_req_valid  = (state_q == DMI_REQ);
  assign dmi_resp_ready = (state_q == DMI_RESP);

  always_comb begin
    if (shift_ir) begin
      tdo = ir_shift[0];
    end else begin
      case (dr_sel)
        SEL_IDCODE: tdo = idcode_shift[0];
        SEL_DTMCS:  tdo = dtmcs_shift[0];
        SEL_DMI:    tdo = dmi_shift[0];
        default:    tdo = bypass_shift;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= IR_IDCODE;
      ir_shift <= '0;
    end else begin
      if (capture_ir)    ir_shift <= 5'b00001;
      else if (shift_ir) ir_shift <= {tdi, ir_shift[4:1]};
      if (tap_reset)      ir <= IR_IDCODE;
      else if (update_ir) ir <= ir_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idcode_shift <= '0;
      dtmcs_shift  <= '0;
      bypass_shift <= 1'b0;
      dmi_shift    <= '0;
    end else if (capture_dr) begin
      case (dr_sel)
        SEL_IDCODE: idcode_shift <= IDCODE_VALUE;
        SEL_DTMCS:  dtmcs_shift  <= dtmcs_capture;
        SEL_DMI:    dmi_shift    <= dmi_capture;
        default:    bypass_shift <= 1'b0;
      endcase
    end else if (shift_dr) begin
      case (dr_sel)
        SEL_IDCODE: idcode_shift <= {tdi, idcode_shift[31:1]};
        SEL_DTMCS:  dtmcs_shift  <= {tdi, dtmcs_shift[31:1]};
        SEL_DMI:    dmi_shift    <= {tdi, dmi_shift[DMI_W-1:1]};
        default:    bypass_shift <= tdi;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DMI_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      DMI_IDLE: if (dmi_launch)     state_d = DMI_REQ;
      DMI_REQ:  if (dmi_req_ready)  state_d = DMI_RESP;
      DMI_RESP: if (dmi_resp_valid) state_d = DMI_IDLE;
      default:                      state_d = DMI_IDLE;
    endcase
    if (dmi_hardreset) state_d = DMI_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmi_req_addr <= '0;
      dmi_req_data <= '0;
      dmi_req_op   <= '0;
      last_addr    <= '0;
      last_data    <= '0;
      dmistat      <= '0;
    end else begin
      if (dmi_launch) begin
        dmi_req_addr <= dmi_shift[DMI_W-1:34];
        dmi_req_data <= dmi_shift[33:2];
        dmi_req_op   <= upd_op;
      end
      if (resp_fire) begin
        last_addr <= dmi_req_addr;
        if (dmi_req_op == 2'd1) last_data <= dmi_resp_data;
      end
      // Sticky error: only the first error is recorded until software clears it.
      if (dmi_hardreset || dmi_reset)                         dmistat <= 2'd0;
      else if (busy_hit && dmistat == 2'd0)                   dmistat <= 2'd3;
      else if (resp_fire && dmi_resp_op != 2'd0 && dmistat == 2'd0) dmistat <= 2'd2;
    end
  end

endmodule
